// File: rtl/demo_sched_pkg.sv
// Shared types, default sizing and width helpers for the demo detector sequencer.
package demo_sched_pkg;

  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned DRAIN_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Hit count must hold every cycle the detector output can be sampled.
  function automatic int unsigned cnt_w(input int unsigned data_w, input int unsigned drain_cyc);
    return $clog2(data_w + drain_cyc + 1);
  endfunction

endpackage

// File: rtl/demo_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module demo_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_any_c
);

  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] k;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    j           = 0;
    k           = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      k = IDX_W'(j);
      if (!grant_any_c && valid[k]) begin
        grant_any_c = 1'b1;
        grant_c[k]  = 1'b1;
        grant_idx_c = k;
      end
    end
  end

endmodule

// File: rtl/demo_sched.sv
// Arbitrates requesters, flushes the demo detector, streams a word MSB-first and returns the hit count.
module demo_sched
  import demo_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int unsigned ID_W      = $clog2(NUM_REQ),
  parameter int unsigned CNT_W     = cnt_w(DATA_W, DRAIN_CYC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      det_rst,
  output logic                      det_a,
  input  logic                      det_w,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          rsp_count,
  output logic                      busy
);

  localparam int unsigned CYC_W = $clog2(DATA_W + DRAIN_CYC + 1);
  localparam logic [CYC_W-1:0] LAST_BIT   = CYC_W'(DATA_W - 1);
  localparam logic [CYC_W-1:0] LAST_DRAIN = CYC_W'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                det_a_q, det_a_d;
  logic                det_flush_q, det_flush_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  grant_c;
  logic [ID_W-1:0]     grant_idx_c;
  logic                grant_any_c;

  demo_rr_arb #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .valid       (req_valid),
    .ptr         (rr_ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  assign req_ready = (state_q == ST_IDLE) ? grant_c : '0;
  // Detector is held in reset for as long as the block itself is.
  assign det_rst   = det_flush_q | ~rst;
  assign det_a     = det_a_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_count = cnt_q;
  assign busy      = busy_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_any_c) begin
          state_d = ST_FLUSH;
          shreg_d = req_data[32'(grant_idx_c) * DATA_W +: DATA_W];
          id_d    = grant_idx_c;
          cnt_d   = '0;
          cyc_d   = '0;
        end
      end
      ST_FLUSH: begin
        state_d = ST_SHIFT;
        cyc_d   = '0;
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        cyc_d   = cyc_q + CYC_W'(1);
        if (cyc_q == LAST_BIT) begin
          cyc_d   = '0;
          state_d = (DRAIN_CYC == 0) ? ST_RESP : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == LAST_DRAIN) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Saturating guard; the window length keeps it from ever reaching max in practice.
    if ((state_q == ST_SHIFT || state_q == ST_DRAIN) && det_w && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);

    det_a_d     = (state_d == ST_SHIFT) ? shreg_d[DATA_W-1] : 1'b0;
    det_flush_d = (state_d == ST_FLUSH);
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cyc_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      det_a_q     <= 1'b0;
      det_flush_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      det_a_q     <= det_a_d;
      det_flush_q <= det_flush_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_demo_sched.sv
// Directed bench for demo_sched with a one-cycle echo stub standing in for the detector.
module tb_demo_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        det_rst, det_a;
  logic        det_w = 1'b0;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_count;
  logic        busy;

  logic [3:0]  req_valid_z;
  logic [31:0] req_data_z;
  logic [3:0]  req_ready_z;
  logic        det_rst_z, det_a_z;
  logic        det_w_z = 1'b0;
  logic        rsp_valid_z, rsp_ready_z;
  logic [1:0]  rsp_id_z;
  logic [3:0]  rsp_count_z;
  logic        busy_z;

  int total = 0;
  int bad   = 0;

  demo_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .det_rst(det_rst), .det_a(det_a), .det_w(det_w), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_count(rsp_count), .busy(busy)
  );

  demo_sched #(.DRAIN_CYC(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_data(req_data_z), .req_ready(req_ready_z),
    .det_rst(det_rst_z), .det_a(det_a_z), .det_w(det_w_z), .rsp_valid(rsp_valid_z),
    .rsp_ready(rsp_ready_z), .rsp_id(rsp_id_z), .rsp_count(rsp_count_z), .busy(busy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    det_w   <= det_a;
    det_w_z <= det_a_z;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [7:0] w);
    req_data[i*8 +: 8] = w;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic rsp_hs();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    int n;
    int seen;
    int fair_id [4];
    int fair_cnt[4];
    fair_id  = '{1, 3, 1, 3};
    fair_cnt = '{2, 4, 2, 4};

    rst = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    req_valid_z = '0; req_data_z = '0; rsp_ready_z = 1'b0;

    // reset values while rst is low
    #13;
    chk("rst_det_rst", 32'(det_rst), 32'd1);
    chk("rst_outs", 32'({det_a, req_ready, rsp_valid, rsp_id, rsp_count, busy}), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_det_rst", 32'(det_rst), 32'd0);

    // single request 0xA5 from requester 0
    set_word(0, 8'hA5); req_valid = 4'b0001;
    #1;
    chk("a5_ready", 32'(req_ready), 32'h1);
    tick();
    chk("a5_flush", 32'({det_rst, det_a, busy, req_ready}), 32'({1'b1, 1'b0, 1'b1, 4'b0000}));
    req_valid = '0;
    w = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("a5_bit", 32'({det_rst, det_a}), 32'({1'b0, w[7-k]}));
    end
    tick();
    chk("a5_drain0", 32'(rsp_valid), 32'd0);
    tick();
    chk("a5_drain1", 32'(rsp_valid), 32'd0);
    tick();
    chk("a5_rsp", 32'({rsp_valid, rsp_id, rsp_count}), 32'({1'b1, 2'd0, 4'd4}));
    rsp_hs();
    chk("a5_idle", 32'(busy), 32'd0);

    // all four valid from reset: grants 0..3 in order
    rst = 1'b0; tick(); rst = 1'b1;
    set_word(0, 8'h01); set_word(1, 8'h03); set_word(2, 8'h07); set_word(3, 8'h0F);
    req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << g));
      tick();
      req_valid[g] = 1'b0;
      wait_rsp(n);
      chk("rr_lat", 32'(n), 32'd11);
      chk("rr_rsp", 32'({rsp_id, rsp_count}), 32'({2'(g), 4'(g + 1)}));
      rsp_hs();
    end

    // fairness: 1 and 3 held valid continuously
    set_word(1, 8'h81); set_word(3, 8'hC3);
    req_valid = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("fair_ready", 32'(req_ready), 32'(4'b0001 << fair_id[g]));
      tick();
      wait_rsp(n);
      chk("fair_ready_busy", 32'(req_ready), 32'd0);
      chk("fair_rsp", 32'({rsp_id, rsp_count}), 32'({2'(fair_id[g]), 4'(fair_cnt[g])}));
      rsp_hs();
    end
    req_valid = '0;

    // backpressure: response held for 20 cycles
    set_word(0, 8'h3C); set_word(2, 8'hE7);
    req_valid = 4'b0101;
    tick();
    req_valid[0] = 1'b0;
    wait_rsp(n);
    for (int k = 0; k < 20; k++) begin
      chk("bp_hold", 32'({rsp_valid, busy, req_ready, rsp_id, rsp_count}),
          32'({1'b1, 1'b1, 4'b0000, 2'd0, 4'd4}));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_next_ready", 32'(req_ready), 32'h4);
    tick();
    chk("bp_next_grant", 32'({busy, rsp_valid, det_rst}), 32'({1'b1, 1'b0, 1'b1}));
    req_valid = '0;
    wait_rsp(n);
    chk("bp_next_rsp", 32'({rsp_id, rsp_count}), 32'({2'd2, 4'd6}));
    rsp_hs();

    // reset in the middle of SHIFT drops the word
    set_word(1, 8'hAA);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_det_rst", 32'(det_rst), 32'd1);
    chk("mid_rst_outs", 32'({det_a, req_ready, rsp_valid, rsp_id, rsp_count, busy}), 32'd0);
    tick();
    rst = 1'b1;
    seen = 0;
    repeat (15) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);
    set_word(2, 8'hFF);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("ff_rsp", 32'({rsp_id, rsp_count}), 32'({2'd2, 4'd8}));
    rsp_hs();

    // edge word 0x00
    set_word(3, 8'h00);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("zero_rsp", 32'({rsp_id, rsp_count}), 32'({2'd3, 4'd0}));
    rsp_hs();

    // no drain cycles: the echoed last bit is missed
    req_data_z[7:0] = 8'hFF;
    req_valid_z = 4'b0001;
    #1;
    chk("z_ready", 32'(req_ready_z), 32'h1);
    tick();
    req_valid_z = '0;
    n = 0;
    while (rsp_valid_z !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("z_lat", 32'(n), 32'd9);
    chk("z_rsp", 32'({rsp_valid_z, rsp_id_z, rsp_count_z}), 32'({1'b1, 2'd0, 4'd7}));
    rsp_ready_z = 1'b1;
    tick();
    rsp_ready_z = 1'b0;
    chk("z_idle", 32'({rsp_valid_z, busy_z}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
